// File: rtl/pw_pkg.sv
// Shared definitions for the Picowizard bus sequencer.
//
// Purpose: address/data widths, the default halt-mailbox address and the
//          sequencer state encoding used by pw_bus_sequencer and pw_mem_mux.
// Ports:   none (package).
package pw_pkg;

    localparam int PW_ADR_W  = 16;
    localparam int PW_DATA_W = 8;

    // Default mailbox sits at the top of the address space, so a core that
    // runs off the end of memory cannot wrap silently past it.
    localparam logic [PW_ADR_W-1:0] PW_HALT_ADR = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        HACC,
        HWAIT,
        RUN,
        STOP
    } pwState_t;

endpackage

// File: rtl/pw_mem_mux.sv
// Host/core memory port multiplexer for the Picowizard bus sequencer.
//
// Purpose: steers the single RAM port to the host (HostSel) or to the core
//          (CoreSel) and turns a core write to the halt mailbox into a
//          mailbox hit instead of a RAM write. With neither select active
//          the RAM port is idle and all outputs are zero.
// Ports:
//   HostSel, CoreSel          port owner selects (mutually exclusive)
//   HostWe/HostAdr/HostWData  host access request fields
//   CpuLdMem/CpuWrtMem        core read/write strobes
//   CpuAdrOut/CpuDataOut      core address and write data
//   MailboxHit                core write to HALT_ADR while the core owns the port
//   MemAdr/MemWData/MemWe/MemRe  RAM port
module pw_mem_mux
    import pw_pkg::*;
#(
    parameter logic [PW_ADR_W-1:0] HALT_ADR = PW_HALT_ADR
) (
    input  logic                 HostSel,
    input  logic                 CoreSel,
    input  logic                 HostWe,
    input  logic [PW_ADR_W-1:0]  HostAdr,
    input  logic [PW_DATA_W-1:0] HostWData,
    input  logic                 CpuLdMem,
    input  logic                 CpuWrtMem,
    input  logic [PW_ADR_W-1:0]  CpuAdrOut,
    input  logic [PW_DATA_W-1:0] CpuDataOut,
    output logic                 MailboxHit,
    output logic [PW_ADR_W-1:0]  MemAdr,
    output logic [PW_DATA_W-1:0] MemWData,
    output logic                 MemWe,
    output logic                 MemRe
);

    assign MailboxHit = CoreSel && CpuWrtMem && (CpuAdrOut == HALT_ADR);

    always_comb begin
        MemAdr   = '0;
        MemWData = '0;
        MemWe    = 1'b0;
        MemRe    = 1'b0;
        if (HostSel) begin
            MemAdr   = HostAdr;
            MemWData = HostWData;
            MemWe    = HostWe;
            MemRe    = !HostWe;
        end else if (CoreSel) begin
            MemAdr   = CpuAdrOut;
            MemWData = CpuDataOut;
            MemRe    = CpuLdMem;
            // The mailbox is not backed by RAM; keep the write off the bus.
            MemWe    = CpuWrtMem && !MailboxHit;
        end
    end

endmodule

// File: rtl/pw_bus_sequencer.sv
// Picowizard bus sequencer: owns the shared program/data memory port.
//
// Purpose: holds the core in reset while an external host loads/inspects
//          memory, runs the core on Start, and stops it on a mailbox write
//          (capturing the halt code) or on Abort. Host accesses take two
//          cycles from the HostReq sample to the one-cycle HostAck pulse,
//          with HostRData valid alongside HostAck.
// Optional feature: define PW_BUS_SEQ_WATCHDOG_EN to add a run-cycle
//          watchdog (parameter WDT_CYCLES, sticky output TimedOut).
// Ports:
//   Clk, Rst                  clock, asynchronous active-high reset
//   HostReq/HostWe/HostAdr/HostWData, HostAck/HostRData   host access port
//   Start, Abort              run control pulses
//   Running, Halted, HaltCode run status
//   CpuEn                     core enable (low holds the core in reset)
//   CpuLdMem/CpuWrtMem/CpuAdrOut/CpuDataOut/CpuDataIn     core memory port
//   MemAdr/MemWData/MemWe/MemRe/MemRData                  RAM port (1-cycle read)
//   TimedOut                  watchdog stop flag (watchdog builds only)
module pw_bus_sequencer
    import pw_pkg::*;
#(
    parameter logic [PW_ADR_W-1:0] HALT_ADR = PW_HALT_ADR,
    parameter int unsigned WDT_CYCLES = 65536
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 HostReq,
    input  logic                 HostWe,
    input  logic [PW_ADR_W-1:0]  HostAdr,
    input  logic [PW_DATA_W-1:0] HostWData,
    output logic                 HostAck,
    output logic [PW_DATA_W-1:0] HostRData,
    input  logic                 Start,
    input  logic                 Abort,
    output logic                 Running,
    output logic                 Halted,
    output logic [PW_DATA_W-1:0] HaltCode,
    output logic                 CpuEn,
    input  logic                 CpuLdMem,
    input  logic                 CpuWrtMem,
    input  logic [PW_ADR_W-1:0]  CpuAdrOut,
    input  logic [PW_DATA_W-1:0] CpuDataOut,
    output logic [PW_DATA_W-1:0] CpuDataIn,
    output logic [PW_ADR_W-1:0]  MemAdr,
    output logic [PW_DATA_W-1:0] MemWData,
    output logic                 MemWe,
    output logic                 MemRe,
    input  logic [PW_DATA_W-1:0] MemRData
`ifdef PW_BUS_SEQ_WATCHDOG_EN
    ,
    output logic                 TimedOut
`endif
);

    pwState_t state, nextState;
    logic     startPend;
    logic     mailboxHit;
    logic     wdtExpire;
    logic     enterRun;
    logic     hostSel, coreSel;

    assign hostSel   = (state == HACC);
    assign coreSel   = (state == RUN);
    assign CpuEn     = coreSel;
    assign Running   = coreSel;
    assign CpuDataIn = MemRData;

    pw_mem_mux #(
        .HALT_ADR (HALT_ADR)
    ) uMemMux (
        .HostSel    (hostSel),
        .CoreSel    (coreSel),
        .HostWe     (HostWe),
        .HostAdr    (HostAdr),
        .HostWData  (HostWData),
        .CpuLdMem   (CpuLdMem),
        .CpuWrtMem  (CpuWrtMem),
        .CpuAdrOut  (CpuAdrOut),
        .CpuDataOut (CpuDataOut),
        .MailboxHit (mailboxHit),
        .MemAdr     (MemAdr),
        .MemWData   (MemWData),
        .MemWe      (MemWe),
        .MemRe      (MemRe)
    );

`ifdef PW_BUS_SEQ_WATCHDOG_EN
    logic [31:0] runCnt;

    assign wdtExpire = coreSel && (runCnt == 32'(WDT_CYCLES - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            runCnt   <= '0;
            TimedOut <= 1'b0;
        end else begin
            if (enterRun) begin
                runCnt   <= '0;
                TimedOut <= 1'b0;
            end else if (coreSel) begin
                runCnt <= runCnt + 32'd1;
                // A mailbox halt in the expiry cycle is a clean halt.
                if (wdtExpire && !mailboxHit) begin
                    TimedOut <= 1'b1;
                end
            end
        end
    end
`else
    assign wdtExpire = 1'b0;
`endif

    // HostAck is high in the first IDLE cycle after an access while the host
    // may still be holding HostReq; ignoring HostReq then keeps a finished
    // request from being serviced twice.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (HostReq && !HostAck) begin
                    nextState = HACC;
                end else if (Start || startPend) begin
                    nextState = RUN;
                end
            end
            HACC:    nextState = HWAIT;
            HWAIT:   nextState = IDLE;
            RUN: begin
                if (mailboxHit || Abort || wdtExpire) begin
                    nextState = STOP;
                end
            end
            STOP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign enterRun = (state == IDLE) && (nextState == RUN);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            startPend <= 1'b0;
            HostAck   <= 1'b0;
            HostRData <= '0;
            Halted    <= 1'b0;
            HaltCode  <= '0;
        end else begin
            state   <= nextState;
            HostAck <= (state == HWAIT);

            // RAM data for a host read arrives during HWAIT.
            if ((state == HWAIT) && !HostWe) begin
                HostRData <= MemRData;
            end

            // A Start that collides with host traffic waits for it to finish.
            if (enterRun) begin
                startPend <= 1'b0;
            end else if (Start && ((state == HACC) || (state == HWAIT) ||
                                   ((state == IDLE) && (nextState == HACC)))) begin
                startPend <= 1'b1;
            end

            if (enterRun) begin
                Halted <= 1'b0;
            end else if (mailboxHit) begin
                Halted   <= 1'b1;
                HaltCode <= CpuDataOut;
            end
        end
    end

endmodule

// File: tb/tb_pw_bus_sequencer.sv
module tb_pw_bus_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        HostReq, HostWe;
    logic [15:0] HostAdr;
    logic [7:0]  HostWData;
    logic        HostAck;
    logic [7:0]  HostRData;
    logic        Start, Abort;
    logic        Running, Halted;
    logic [7:0]  HaltCode;
    logic        CpuEn;
    logic        CpuLdMem, CpuWrtMem;
    logic [15:0] CpuAdrOut;
    logic [7:0]  CpuDataOut, CpuDataIn;
    logic [15:0] MemAdr;
    logic [7:0]  MemWData;
    logic        MemWe, MemRe;
    logic [7:0]  MemRData = 8'h00;
`ifdef PW_BUS_SEQ_WATCHDOG_EN
    logic        TimedOut;
`endif

    int nChecks = 0;
    int nPass   = 0;

    // Reference state: expected memory image and expected halt status.
    logic [7:0] mdl [logic [15:0]];
    logic       mdlHalted = 1'b0;
    logic [7:0] mdlCode   = 8'h00;

    always #5 Clk = ~Clk;

    pw_bus_sequencer #(.WDT_CYCLES(100)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .HostReq    (HostReq),
        .HostWe     (HostWe),
        .HostAdr    (HostAdr),
        .HostWData  (HostWData),
        .HostAck    (HostAck),
        .HostRData  (HostRData),
        .Start      (Start),
        .Abort      (Abort),
        .Running    (Running),
        .Halted     (Halted),
        .HaltCode   (HaltCode),
        .CpuEn      (CpuEn),
        .CpuLdMem   (CpuLdMem),
        .CpuWrtMem  (CpuWrtMem),
        .CpuAdrOut  (CpuAdrOut),
        .CpuDataOut (CpuDataOut),
        .CpuDataIn  (CpuDataIn),
        .MemAdr     (MemAdr),
        .MemWData   (MemWData),
        .MemWe      (MemWe),
        .MemRe      (MemRe),
        .MemRData   (MemRData)
`ifdef PW_BUS_SEQ_WATCHDOG_EN
        ,
        .TimedOut   (TimedOut)
`endif
    );

    // Synchronous single-port RAM, one-cycle read latency.
    logic [7:0] ram [0:65535];
    int         memWrTop = 0;
    always @(posedge Clk) begin
        if (MemWe) ram[MemAdr] <= MemWData;
        if (MemRe) MemRData <= ram[MemAdr];
        if (MemWe && MemAdr == 16'hFFFF) memWrTop <= memWrTop + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_core();
        CpuLdMem = 1'b0; CpuWrtMem = 1'b0; CpuAdrOut = 16'h0; CpuDataOut = 8'h0; Abort = 1'b0;
    endtask

    // One host access, checked for latency, RAM port use and read data.
    task automatic host_xfer(input bit we, input logic [15:0] adr, input logic [7:0] wd,
                             input logic [7:0] expRd, input string nm);
        int  cyc;
        bit  memOk;
        HostReq = 1'b1; HostWe = we; HostAdr = adr; HostWData = wd;
        cyc = 0; memOk = 1'b0;
        while (!HostAck && cyc < 40) begin
            tick();
            cyc++;
            if (cyc == 1)
                memOk = we ? (MemWe && !MemRe && MemAdr == adr && MemWData == wd)
                           : (MemRe && !MemWe && MemAdr == adr);
        end
        HostReq = 1'b0;
        chk({nm, "_ack_latency"}, cyc - 1, 2);
        chk({nm, "_mem_port"}, memOk, 1);
        if (!we) chk({nm, "_rdata"}, HostRData, expRd);
        else mdl[adr] = wd;
        tick();
        chk({nm, "_ack_pulse"}, HostAck, 0);
    endtask

    // Run a program of nOps random loads/stores in 0x0100..0x010F, then end
    // with a mailbox store (optionally with Abort) or with Abort alone.
    task automatic run_program(input int nOps, input bit endMailbox, input bit abortToo,
                               input logic [7:0] code, input string nm);
        logic [15:0] adr;
        logic [7:0]  expRd;
        bit          pendRd;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk({nm, "_entry_run"}, {Running, CpuEn, Halted}, 3'b110);
        pendRd = 1'b0;
        for (int i = 0; i <= nOps; i++) begin
            if (pendRd) chk({nm, "_core_rd"}, CpuDataIn, expRd);
            pendRd = 1'b0;
            clear_core();
            if (i < nOps) begin
                adr = 16'h0100 + 16'($urandom_range(0, 15));
                CpuAdrOut = adr;
                if ($urandom_range(0, 1) == 1) begin
                    CpuWrtMem = 1'b1; CpuDataOut = 8'($urandom); mdl[adr] = CpuDataOut;
                end else begin
                    CpuLdMem = 1'b1; expRd = mdl[adr]; pendRd = 1'b1;
                end
            end else if (endMailbox) begin
                CpuWrtMem = 1'b1; CpuAdrOut = 16'hFFFF; CpuDataOut = code; Abort = abortToo;
                mdlHalted = 1'b1; mdlCode = code;
            end else begin
                Abort = 1'b1; mdlHalted = 1'b0;
            end
            #1;
            chk({nm, "_running"}, Running, 1);
            if (i == nOps && endMailbox) chk({nm, "_mbox_no_we"}, MemWe, 0);
            tick();
        end
        clear_core();
        chk({nm, "_stop_cpuen"}, {Running, CpuEn}, 2'b00);
        chk({nm, "_halted"}, Halted, mdlHalted);
        chk({nm, "_haltcode"}, HaltCode, mdlCode);
        tick();
    endtask

    typedef struct {
        bit          we;
        logic [15:0] adr;
        logic [7:0]  wd;
        logic [7:0]  expRd;
    } hostVec_t;

    hostVec_t tbl [6];

    initial begin
        int          cyc;
        logic [15:0] a;
        Rst = 1'b1; HostReq = 1'b0; HostWe = 1'b0; HostAdr = 16'h0; HostWData = 8'h0;
        Start = 1'b0;
        clear_core();

        tbl[0] = '{1'b1, 16'h0010, 8'hA5, 8'h00};
        tbl[1] = '{1'b0, 16'h0010, 8'h00, 8'hA5};
        tbl[2] = '{1'b1, 16'h0011, 8'h5A, 8'h00};
        tbl[3] = '{1'b0, 16'h0011, 8'h00, 8'h5A};
        tbl[4] = '{1'b1, 16'h0000, 8'hFF, 8'h00};
        tbl[5] = '{1'b0, 16'h0000, 8'h00, 8'hFF};

        tick(); tick();
        chk("reset_ctrl", {Running, CpuEn, Halted, HostAck, MemWe, MemRe}, 6'b0);
        chk("reset_data", {HaltCode, HostRData, MemAdr, MemWData}, 40'h0);
        Rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            host_xfer(tbl[i].we, tbl[i].adr, tbl[i].wd, tbl[i].expRd, $sformatf("tbl%0d", i));

        // Preload the random-test window.
        for (int i = 0; i < 16; i++)
            host_xfer(1'b1, 16'h0100 + 16'(i), 8'($urandom), 8'h00, "preload");

        // Program ending with a mailbox store of 0x3C.
        run_program(5, 1'b1, 1'b0, 8'h3C, "mbox3c");
        chk("mbox_ram_untouched", memWrTop, 0);

        // Start together with HostReq: host access first, run right after.
        HostReq = 1'b1; HostWe = 1'b0; HostAdr = 16'h0010; Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("pend_hacc_not_run", Running, 0);
        tick();
        tick();
        chk("pend_ack", {HostAck, HostRData, Running}, {1'b1, 8'hA5, 1'b0});
        HostReq = 1'b0;
        tick();
        chk("pend_run", {Running, HostAck}, 2'b10);
        CpuWrtMem = 1'b1; CpuAdrOut = 16'hFFFF; CpuDataOut = 8'h42;
        tick();
        clear_core();
        mdlHalted = 1'b1; mdlCode = 8'h42;
        chk("pend_halt", {Halted, HaltCode}, {1'b1, 8'h42});
        tick();

        // HostReq while running is held off until the core stops.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        a = 16'h0105;
        HostReq = 1'b1; HostWe = 1'b0; HostAdr = a;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (HostAck || !Running) cyc++;
        end
        chk("run_hostreq_held", cyc, 0);
        CpuWrtMem = 1'b1; CpuAdrOut = 16'hFFFF; CpuDataOut = 8'h77;
        tick();
        clear_core();
        mdlHalted = 1'b1; mdlCode = 8'h77;
        cyc = 0;
        while (!HostAck && cyc < 20) begin tick(); cyc++; end
        HostReq = 1'b0;
        chk("run_hostreq_ack", HostAck, 1);
        chk("run_hostreq_rdata", HostRData, mdl[a]);
        tick();

        // Abort on run cycle 20.
        run_program(19, 1'b0, 1'b0, 8'h00, "abort20");

        // Randomised mix of host accesses and runs.
        for (int it = 0; it < 25; it++) begin
            a = 16'h0100 + 16'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0: host_xfer(1'b1, a, 8'($urandom), 8'h00, "rnd_wr");
                1: host_xfer(1'b0, a, 8'h00, mdl[a], "rnd_rd");
                default: run_program($urandom_range(1, 12), 1'($urandom_range(0, 1)),
                                     1'($urandom_range(0, 1)), 8'($urandom), "rnd_run");
            endcase
        end
        chk("rnd_ram_top_untouched", memWrTop, 0);

        // Reset in the middle of a host access drops it.
        HostReq = 1'b1; HostWe = 1'b1; HostAdr = 16'h0200; HostWData = 8'h99;
        tick();
        chk("rst_hacc_we", MemWe, 1);
        Rst = 1'b1;
        #1;
        chk("rst_hacc_ctrl", {Running, CpuEn, Halted, HostAck, MemWe, MemRe}, 6'b0);
        chk("rst_hacc_data", {HaltCode, HostRData, MemAdr, MemWData}, 40'h0);
        HostReq = 1'b0;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (HostAck) cyc++; end
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); if (HostAck) cyc++; end
        chk("rst_hacc_no_ack", cyc, 0);
        mdlHalted = 1'b0; mdlCode = 8'h00;

`ifdef PW_BUS_SEQ_WATCHDOG_EN
        // Endless loop: the watchdog stops the core after 100 run cycles.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        CpuLdMem = 1'b1; CpuAdrOut = 16'h0100;
        cyc = 0;
        while (Running && cyc < 300) begin cyc++; tick(); end
        clear_core();
        chk("wdt_run_cycles", cyc, 100);
        chk("wdt_flags", {TimedOut, Halted}, 2'b10);
        tick();
        run_program(3, 1'b1, 1'b0, 8'h11, "wdt_next");
        chk("wdt_cleared", TimedOut, 0);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
